// File: rtl/enc_pkg.sv
// Shared definitions for the streaming priority encoder: index-width helper,
// priority-mode constants and the handshake state type.
package enc_pkg;

    localparam bit LSB_FIRST_MODE = 1'b1;
    localparam bit MSB_FIRST_MODE = 1'b0;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/prio_enc_stream_comb.sv
// Combinational priority encoder: index of the winning set bit, an any-set
// flag and a one-hot mask of the winner, which the caller uses to clear that bit.
module prio_enc_comb
    import enc_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = LSB_FIRST_MODE,
    localparam int IDX_W    = clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] vec,
    output logic [IDX_W-1:0] idx,
    output logic             any,
    output logic [WIDTH-1:0] onehot
);

    // Later loop iterations overwrite earlier ones, so scan towards the winner.
    always_comb begin
        idx    = '0;
        onehot = '0;
        any    = |vec;
        if (LSB_FIRST == LSB_FIRST_MODE) begin
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (vec[i]) begin
                    idx    = IDX_W'(i);
                    onehot = WIDTH'(1) << i;
                end
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (vec[i]) begin
                    idx    = IDX_W'(i);
                    onehot = WIDTH'(1) << i;
                end
            end
        end
    end

endmodule

// File: rtl/prio_enc_stream.sv
// Streaming priority encoder: accepts a request vector and emits the index of
// each set bit, one per output beat in priority order, flagging the final beat.
module prio_enc_stream
    import enc_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = LSB_FIRST_MODE,
    localparam int IDX_W    = clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_vec,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last,
    output logic             out_zero
);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] pend;
    logic             zero;
    logic             busy;
    logic             accept;
    logic             fire;
    logic             enc_any;
    logic [WIDTH-1:0] enc_onehot;
    logic             at_most_one;

    prio_enc_comb #(
        .WIDTH     (WIDTH),
        .LSB_FIRST (LSB_FIRST)
    ) u_enc (
        .vec    (pend),
        .idx    (out_idx),
        .any    (enc_any),
        .onehot (enc_onehot)
    );

    assign busy        = (state == EMIT);
    assign at_most_one = ((pend & (pend - WIDTH'(1))) == '0);
    assign out_valid   = busy;
    // Gated by busy so the flag reads 0 while idle even though pend is empty.
    assign out_last    = busy & at_most_one;
    assign out_zero    = zero;
    assign in_ready    = !busy || (out_valid && out_ready && out_last);
    assign accept      = in_valid && in_ready;
    assign fire        = out_valid && out_ready;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = EMIT;
            EMIT: if (fire && out_last && !accept) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A same-edge accept replaces whatever remains of the finishing vector.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend <= '0;
            zero <= 1'b0;
        end else if (accept) begin
            pend <= in_vec;
            zero <= (in_vec == '0);
        end else if (fire && enc_any) begin
            pend <= pend & ~enc_onehot;
        end
    end

endmodule

// File: tb/tb_prio_enc_stream.sv
// Directed bench for prio_enc_stream: LSB-first and MSB-first 8-bit instances
// plus a 5-bit instance, driven with hand-computed beat sequences.
module tb_prio_enc_stream;

    logic clk;
    logic rst;
    logic out_ready;
    int   vectors;
    int   miscompares;

    logic       iv_a, ir_a, ov_a, last_a, zero_a;
    logic [7:0] vec_a;
    logic [2:0] idx_a;

    logic       iv_m, ir_m, ov_m, last_m, zero_m;
    logic [7:0] vec_m;
    logic [2:0] idx_m;

    logic       iv_c, ir_c, ov_c, last_c, zero_c;
    logic [4:0] vec_c;
    logic [2:0] idx_c;

    prio_enc_stream #(.WIDTH(8), .LSB_FIRST(1'b1)) dut_a (
        .clk(clk), .rst(rst), .in_valid(iv_a), .in_ready(ir_a), .in_vec(vec_a),
        .out_valid(ov_a), .out_ready(out_ready), .out_idx(idx_a),
        .out_last(last_a), .out_zero(zero_a)
    );

    prio_enc_stream #(.WIDTH(8), .LSB_FIRST(1'b0)) dut_m (
        .clk(clk), .rst(rst), .in_valid(iv_m), .in_ready(ir_m), .in_vec(vec_m),
        .out_valid(ov_m), .out_ready(out_ready), .out_idx(idx_m),
        .out_last(last_m), .out_zero(zero_m)
    );

    prio_enc_stream #(.WIDTH(5), .LSB_FIRST(1'b1)) dut_c (
        .clk(clk), .rst(rst), .in_valid(iv_c), .in_ready(ir_c), .in_vec(vec_c),
        .out_valid(ov_c), .out_ready(out_ready), .out_idx(idx_c),
        .out_last(last_c), .out_zero(zero_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        #1;
        vectors++;
        if ({ov_a, idx_a, last_a, zero_a, ir_a} !== {1'b0, 3'd0, 1'b0, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL reset_state got v=%b i=%0d l=%b z=%b r=%b want v=0 i=0 l=0 z=0 r=1",
                     ov_a, idx_a, last_a, zero_a, ir_a);
        end
        @(negedge clk);
        rst = 1'b0;
        // load all-ones, consume two beats, then reset asynchronously mid-vector
        vec_a = 8'hFF;
        iv_a  = 1'b1;
        @(negedge clk);
        iv_a = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        vectors++;
        if (ov_a !== 1'b1 || idx_a !== 3'd2) begin
            miscompares++;
            $display("FAIL reset_pre got v=%b i=%0d want v=1 i=2", ov_a, idx_a);
        end
        #1;
        rst = 1'b1;
        #1;
        vectors++;
        if ({ov_a, idx_a, last_a, zero_a, ir_a} !== {1'b0, 3'd0, 1'b0, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL reset_async got v=%b i=%0d l=%b z=%b r=%b want v=0 i=0 l=0 z=0 r=1",
                     ov_a, idx_a, last_a, zero_a, ir_a);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        vectors++;
        if (ov_a !== 1'b0 || ir_a !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_release got v=%b r=%b want v=0 r=1", ov_a, ir_a);
        end
    endtask

    task automatic test_lsb_first();
        logic [2:0] exp_idx [3] = '{3'd2, 3'd4, 3'd7};
        @(negedge clk);
        out_ready = 1'b1;
        vec_a     = 8'b1001_0100;
        iv_a      = 1'b1;
        @(negedge clk);
        iv_a = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            vectors++;
            if (ov_a !== 1'b1 || idx_a !== exp_idx[k] || last_a !== (k == 2) || ir_a !== (k == 2)) begin
                miscompares++;
                $display("FAIL lsb_beat%0d got v=%b i=%0d l=%b r=%b want v=1 i=%0d l=%b r=%b",
                         k, ov_a, idx_a, last_a, ir_a, exp_idx[k], (k == 2), (k == 2));
            end
            @(negedge clk);
        end
        #1;
        vectors++;
        if (ov_a !== 1'b0) begin
            miscompares++;
            $display("FAIL lsb_done got v=%b want v=0", ov_a);
        end
    endtask

    task automatic test_msb_first();
        logic [2:0] exp_idx [3] = '{3'd7, 3'd4, 3'd2};
        @(negedge clk);
        out_ready = 1'b1;
        vec_m     = 8'b1001_0100;
        iv_m      = 1'b1;
        @(negedge clk);
        iv_m = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            vectors++;
            if (ov_m !== 1'b1 || idx_m !== exp_idx[k] || last_m !== (k == 2)) begin
                miscompares++;
                $display("FAIL msb_beat%0d got v=%b i=%0d l=%b want v=1 i=%0d l=%b",
                         k, ov_m, idx_m, last_m, exp_idx[k], (k == 2));
            end
            @(negedge clk);
        end
        #1;
        vectors++;
        if (ov_m !== 1'b0) begin
            miscompares++;
            $display("FAIL msb_done got v=%b want v=0", ov_m);
        end
    endtask

    task automatic test_zero();
        @(negedge clk);
        out_ready = 1'b1;
        vec_a     = 8'h00;
        iv_a      = 1'b1;
        @(negedge clk);
        iv_a = 1'b0;
        #1;
        vectors++;
        if ({ov_a, idx_a, last_a, zero_a} !== {1'b1, 3'd0, 1'b1, 1'b1}) begin
            miscompares++;
            $display("FAIL zero_beat got v=%b i=%0d l=%b z=%b want v=1 i=0 l=1 z=1",
                     ov_a, idx_a, last_a, zero_a);
        end
        @(negedge clk);
        #1;
        vectors++;
        if (ov_a !== 1'b0) begin
            miscompares++;
            $display("FAIL zero_single got v=%b want v=0", ov_a);
        end
    endtask

    task automatic test_full_stall();
        int nxt;
        nxt = 0;
        @(negedge clk);
        out_ready = 1'b1;
        vec_a     = 8'hFF;
        iv_a      = 1'b1;
        @(negedge clk);
        iv_a = 1'b0;
        for (int cyc = 0; cyc < 40 && nxt < 8; cyc++) begin
            out_ready = ((cyc % 2) == 1);
            #1;
            vectors++;
            if (ov_a !== 1'b1 || idx_a !== 3'(nxt) || last_a !== (nxt == 7)) begin
                miscompares++;
                $display("FAIL full_cyc%0d got v=%b i=%0d l=%b want v=1 i=%0d l=%b",
                         cyc, ov_a, idx_a, last_a, nxt, (nxt == 7));
            end
            if (out_ready) nxt++;
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        vectors++;
        if (nxt != 8 || ov_a !== 1'b0) begin
            miscompares++;
            $display("FAIL full_count got beats=%0d v=%b want beats=8 v=0", nxt, ov_a);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        out_ready = 1'b1;
        vec_a     = 8'h01;
        iv_a      = 1'b1;
        @(negedge clk);
        vec_a = 8'h80;
        #1;
        vectors++;
        if ({ov_a, idx_a, last_a, ir_a} !== {1'b1, 3'd0, 1'b1, 1'b1}) begin
            miscompares++;
            $display("FAIL b2b_first got v=%b i=%0d l=%b r=%b want v=1 i=0 l=1 r=1",
                     ov_a, idx_a, last_a, ir_a);
        end
        @(negedge clk);
        iv_a = 1'b0;
        #1;
        vectors++;
        if ({ov_a, idx_a, last_a} !== {1'b1, 3'd7, 1'b1}) begin
            miscompares++;
            $display("FAIL b2b_second got v=%b i=%0d l=%b want v=1 i=7 l=1", ov_a, idx_a, last_a);
        end
        @(negedge clk);
        #1;
        vectors++;
        if (ov_a !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_done got v=%b want v=0", ov_a);
        end
    endtask

    task automatic test_width5();
        @(negedge clk);
        out_ready = 1'b1;
        vec_c     = 5'b1_0001;
        iv_c      = 1'b1;
        @(negedge clk);
        iv_c = 1'b0;
        #1;
        vectors++;
        if ({ov_c, idx_c, last_c} !== {1'b1, 3'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL w5_beat0 got v=%b i=%0d l=%b want v=1 i=0 l=0", ov_c, idx_c, last_c);
        end
        @(negedge clk);
        #1;
        vectors++;
        if ({ov_c, idx_c, last_c} !== {1'b1, 3'd4, 1'b1}) begin
            miscompares++;
            $display("FAIL w5_beat1 got v=%b i=%0d l=%b want v=1 i=4 l=1", ov_c, idx_c, last_c);
        end
        @(negedge clk);
        #1;
        vectors++;
        if (ov_c !== 1'b0) begin
            miscompares++;
            $display("FAIL w5_done got v=%b want v=0", ov_c);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst       = 1'b1;
        out_ready = 1'b1;
        iv_a = 1'b0; vec_a = 8'h00;
        iv_m = 1'b0; vec_m = 8'h00;
        iv_c = 1'b0; vec_c = 5'h00;
        test_reset();
        test_lsb_first();
        test_msb_first();
        test_zero();
        test_full_stall();
        test_back_to_back();
        test_width5();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
